udp_rx_pkt_fifo: RTL and testbench
==================================

Name: udp_rx_pkt_fifo

Overview:
Parametrised successor to the fixed 8→32 packer and receive FIFO pair in the Ethernet receive path. It packs the UDP payload byte stream into DATA_BYTES-wide words with per-lane tkeep. Each frame is stored speculatively, then committed on FCS pass or rolled back on FCS fail, overflow or FCS timeout. Only CRC-clean frames reach the AXI-Stream master. It sits between udp_header_rx/fcs_rx and the async clock-crossing FIFO, in the GMII receive clock domain.

Parameters:
DATA_BYTES, 4, output word width in bytes (1..16); tdata = 8*DATA_BYTES bits.
DEPTH, 512, FIFO depth in words; power of two, ≥4.
FCS_TIMEOUT, 16, cycles to wait after the last payload byte for crc_valid/crc_error before discarding.

Ports:
aclk  in  1  GMII receive clock.
aresetn  in  1  asynchronous active-low reset.
data_in  in  8  payload byte.
udp_data_valid  in  1  data_in is a payload byte this cycle.
udp_data_tlast  in  1  last payload byte; qualified by udp_data_valid.
crc_valid  in  1  one-cycle pulse: frame FCS correct.
crc_error  in  1  one-cycle pulse: frame FCS wrong.
m_axis_tdata  out  8*DATA_BYTES  packed payload word.
m_axis_tkeep  out  DATA_BYTES  valid-lane mask.
m_axis_tvalid  out  1  AXI-Stream valid.
m_axis_tlast  out  1  last word of frame.
m_axis_tready  in  1  AXI-Stream ready.
frame_ok  out  1  pulse: frame committed.
drop_crc  out  1  pulse: frame discarded on crc_error.
drop_ovf  out  1  pulse: frame discarded on overflow.
drop_tmo  out  1  pulse: frame discarded on FCS timeout or preemption.
fifo_level  out  $clog2(DEPTH)+1  committed words not yet read.

Behaviour:
- Reset: all outputs 0. State IDLE. Pointers rd_ptr, wr_ptr (committed) and wr_tmp (speculative) are 0. Lane counter is 0.
- Pointers are $clog2(DEPTH)+1 bits with MSB wrap.
  - full = wr_tmp and rd_ptr differ only in the MSB.
  - empty = (rd_ptr == wr_ptr).
- Packing: the first byte of a frame goes to lane DATA_BYTES-1, i.e. tdata[8*DATA_BYTES-1 -: 8], in network order. Subsequent bytes fill descending lanes.
- A word is written at wr_tmp when:
  - lane 0 is filled, or
  - udp_data_tlast is seen.
- A partial last word has unused lanes zeroed and their tkeep bits cleared. The stored tlast equals udp_data_tlast. The lane counter returns to DATA_BYTES-1 after every write.
- States:
  - IDLE → RECV on the first udp_data_valid.
  - RECV → WAIT_FCS on udp_data_valid & udp_data_tlast.
  - WAIT_FCS → IDLE on crc_valid, crc_error, timeout, or preemption.
- Outcomes in WAIT_FCS:
  - crc_valid and no overflow flag: wr_ptr <= wr_tmp; frame_ok pulses the next cycle.
  - crc_error: wr_tmp <= wr_ptr; drop_crc pulses.
  - crc_valid with the overflow flag set: wr_tmp <= wr_ptr; drop_ovf pulses (not frame_ok).
  - If crc_valid and crc_error occur in the same cycle, crc_error wins.
- Overflow: if a word write is due while full, the word is not written and the overflow flag is set. Reception continues to tlast without further writes. The flag clears on leaving WAIT_FCS.
- Timeout:
  - A counter starts at 0 on entering WAIT_FCS.
  - At FCS_TIMEOUT cycles: rollback, drop_tmo, → IDLE.
  - Preemption: if udp_data_valid arrives in WAIT_FCS, the pending frame is rolled back with drop_tmo, and that byte starts a new frame in RECV (lane DATA_BYTES-1, stored at the rolled-back wr_tmp).
- crc_valid/crc_error seen in IDLE or RECV are ignored.
- Read side is first-word-fall-through:
  - m_axis_tvalid = !empty, registered. It rises 1 cycle after the commit.
  - Data and keep are held stable while tvalid & !tready.
  - rd_ptr advances on tvalid & tready.
  - Read and commit may occur in the same cycle.
- Memory: inferred simple dual-port RAM, word = tdata + tkeep + tlast.
- fifo_level = wr_ptr − rd_ptr, updated one cycle after a commit or read.
- Asynchronous reset mid-frame: all state and pointers clear immediately; no drop pulse; the read side empties.

Test Plan:
- DATA_BYTES=4, 8-byte frame 01..08 then crc_valid → words 01020304/keep F, 05060708/keep F/tlast; frame_ok=1; fifo_level 2→0 after reads.
- 5-byte frame AA..EE then crc_valid → AABBCCDD/F, EE000000/keep 8/tlast.
- 12-byte frame then crc_error → drop_crc=1; tvalid stays 0; fifo_level=0; a following good 4-byte frame is output correctly.
- DEPTH=4, tready=0, 20-byte frame then crc_valid → drop_ovf=1, no frame_ok; after tready=1, only previously committed words are output.
- 4-byte frame with no FCS pulse → drop_tmo at cycle FCS_TIMEOUT; tvalid stays 0. Repeat with a new frame arriving in WAIT_FCS → drop_tmo, and the new frame is committed intact.
- tready toggled 1010…, 3 back-to-back 6-byte good frames → 6 words, tlast on words 2, 4, 6, tkeep C on each tlast word, no data loss or duplication.

Source files
------------

// File: rtl/udp_rx_pkt_fifo.sv
// UDP payload packer and receive FIFO. It packs the byte stream into DATA_BYTES-wide words and
// holds each frame speculatively until the FCS verdict. Only CRC-clean frames reach the master.
module udp_rx_pkt_fifo #(
    parameter int unsigned DATA_BYTES  = 4,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned FCS_TIMEOUT = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [7:0]                data_in,
    input  logic                      udp_data_valid,
    input  logic                      udp_data_tlast,
    input  logic                      crc_valid,
    input  logic                      crc_error,
    output logic [8*DATA_BYTES-1:0]   m_axis_tdata,
    output logic [DATA_BYTES-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic                      frame_ok,
    output logic                      drop_crc,
    output logic                      drop_ovf,
    output logic                      drop_tmo,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned WW = DW + DATA_BYTES + 1;
    localparam int unsigned LW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned TW = (FCS_TIMEOUT > 1) ? $clog2(FCS_TIMEOUT) : 1;
    localparam logic [LW-1:0] LaneTop = LW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TmoLast = TW'(FCS_TIMEOUT - 1);
    localparam logic [PW-1:0] MsbOnly = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {StIdle, StRecv, StWaitFcs} state_e;

    state_e                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d, lane_cur;
    logic [DW-1:0]         word_q, word_d, word_cur;
    logic [DATA_BYTES-1:0] keep_q, keep_d, keep_cur;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d, rd_ptr_q, rd_ptr_d, base_ptr;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ovf_q, ovf_d;
    logic                  frame_ok_q, frame_ok_d, drop_crc_q, drop_crc_d;
    logic                  drop_ovf_q, drop_ovf_d, drop_tmo_q, drop_tmo_d;
    logic                  tvalid_q, tvalid_d, pop;
    logic                  start, accept, leave, commit, full, we;
    logic [AW-1:0]         waddr;
    logic [WW-1:0]         wdata, rd_word_q;
    logic [WW-1:0]         mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        word_d     = word_q;
        keep_d     = keep_q;
        wr_ptr_d   = wr_ptr_q;
        wr_tmp_d   = wr_tmp_q;
        ovf_d      = ovf_q;
        tmo_d      = '0;
        frame_ok_d = 1'b0;
        drop_crc_d = 1'b0;
        drop_ovf_d = 1'b0;
        drop_tmo_d = 1'b0;
        base_ptr   = wr_tmp_q;
        start      = 1'b0;
        accept     = 1'b0;
        leave      = 1'b0;
        commit     = 1'b0;
        full       = 1'b0;
        lane_cur   = lane_q;
        word_cur   = word_q;
        keep_cur   = keep_q;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;

        unique case (state_q)
            StIdle: begin
                start  = udp_data_valid;
                accept = udp_data_valid;
            end
            StRecv: accept = udp_data_valid;
            StWaitFcs: begin
                leave = crc_valid | crc_error | udp_data_valid | (tmo_q == TmoLast);
                if (crc_error)                drop_crc_d = 1'b1;
                else if (crc_valid && ovf_q)  drop_ovf_d = 1'b1;
                else if (crc_valid)           commit     = 1'b1;
                else if (leave)               drop_tmo_d = 1'b1;
                else                          tmo_d      = tmo_q + 1'b1;
                frame_ok_d = commit;
                if (leave) begin
                    state_d = StIdle;
                    ovf_d   = 1'b0;
                    if (commit) begin
                        wr_ptr_d = wr_tmp_q;
                    end else begin
                        wr_tmp_d = wr_ptr_q;
                        base_ptr = wr_ptr_q;
                    end
                end
                // A byte arriving here opens a new frame on top of the resolved pointers.
                start  = udp_data_valid;
                accept = udp_data_valid;
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            lane_cur = LaneTop;
            word_cur = '0;
            keep_cur = '0;
        end

        if (accept) begin
            for (int unsigned l = 0; l < DATA_BYTES; l++) begin
                if (lane_cur == LW'(l)) begin
                    word_cur[8*l +: 8] = data_in;
                    keep_cur[l]        = 1'b1;
                end
            end
            if (lane_cur == '0 || udp_data_tlast) begin
                full = ((base_ptr ^ rd_ptr_q) == MsbOnly);
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    we       = 1'b1;
                    waddr    = base_ptr[AW-1:0];
                    wdata    = {word_cur, keep_cur, udp_data_tlast};
                    wr_tmp_d = base_ptr + 1'b1;
                end
                lane_d = LaneTop;
                word_d = '0;
                keep_d = '0;
            end else begin
                lane_d = lane_cur - 1'b1;
                word_d = word_cur;
                keep_d = keep_cur;
            end
            state_d = udp_data_tlast ? StWaitFcs : StRecv;
        end
    end

    // Read side: the registered RAM output always tracks the head-to-be, so data holds under stall.
    always_comb begin
        pop      = tvalid_q & m_axis_tready;
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        tvalid_d = (rd_ptr_d != wr_ptr_q);
    end

    always_ff @(posedge aclk) begin
        if (we) mem[waddr] <= wdata;
        rd_word_q <= mem[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            lane_q     <= '0;
            word_q     <= '0;
            keep_q     <= '0;
            wr_ptr_q   <= '0;
            wr_tmp_q   <= '0;
            rd_ptr_q   <= '0;
            tmo_q      <= '0;
            ovf_q      <= 1'b0;
            frame_ok_q <= 1'b0;
            drop_crc_q <= 1'b0;
            drop_ovf_q <= 1'b0;
            drop_tmo_q <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            keep_q     <= keep_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_tmp_q   <= wr_tmp_d;
            rd_ptr_q   <= rd_ptr_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            frame_ok_q <= frame_ok_d;
            drop_crc_q <= drop_crc_d;
            drop_ovf_q <= drop_ovf_d;
            drop_tmo_q <= drop_tmo_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tvalid_q ? rd_word_q[WW-1 -: DW] : '0;
    assign m_axis_tkeep  = tvalid_q ? rd_word_q[DATA_BYTES:1] : '0;
    assign m_axis_tlast  = tvalid_q & rd_word_q[0];
    assign frame_ok      = frame_ok_q;
    assign drop_crc      = drop_crc_q;
    assign drop_ovf      = drop_ovf_q;
    assign drop_tmo      = drop_tmo_q;
    assign fifo_level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_udp_rx_pkt_fifo.sv
// Self-checking bench for udp_rx_pkt_fifo: directed scenarios plus randomized frames, checked
// against a queue of expected words built from the frame bytes.
module tb_udp_rx_pkt_fifo;
    localparam int unsigned DB    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;
    localparam int unsigned DW    = 8 * DB;
    localparam int unsigned LVW   = $clog2(DEPTH) + 1;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [7:0]     data_in = '0;
    logic           udp_data_valid = 1'b0;
    logic           udp_data_tlast = 1'b0;
    logic           crc_valid = 1'b0;
    logic           crc_error = 1'b0;
    logic [DW-1:0]  m_axis_tdata;
    logic [DB-1:0]  m_axis_tkeep;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready = 1'b0;
    logic           frame_ok, drop_crc, drop_ovf, drop_tmo;
    logic [LVW-1:0] fifo_level;

    udp_rx_pkt_fifo #(.DATA_BYTES(DB), .DEPTH(DEPTH), .FCS_TIMEOUT(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn), .data_in(data_in),
        .udp_data_valid(udp_data_valid), .udp_data_tlast(udp_data_tlast),
        .crc_valid(crc_valid), .crc_error(crc_error),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .frame_ok(frame_ok), .drop_crc(drop_crc),
        .drop_ovf(drop_ovf), .drop_tmo(drop_tmo), .fifo_level(fifo_level)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          rdy_mode = 0;
    int          cnt_ok = 0, cnt_crc = 0, cnt_ovf = 0, cnt_tmo = 0;
    int          exp_ok = 0, exp_crc = 0, exp_ovf = 0, exp_tmo = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  fr[64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_word();
        return 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
    endfunction

    // Output monitor and pulse counters.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (frame_ok) cnt_ok++;
            if (drop_crc) cnt_crc++;
            if (drop_ovf) cnt_ovf++;
            if (drop_tmo) cnt_tmo++;
            if (m_axis_tvalid && m_axis_tready) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_word: observed %0h expected none", obs_word());
                end
                if (exp_q.size() != 0) check("axis_word", obs_word(), exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = ~m_axis_tready;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic send_frame(input int len, input int max_gap);
        for (int i = 0; i < len; i++) begin
            data_in        = fr[i];
            udp_data_valid = 1'b1;
            udp_data_tlast = (i == len - 1);
            tick();
            udp_data_valid = 1'b0;
            udp_data_tlast = 1'b0;
            if (i != len - 1) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic fcs(input bit good);
        crc_valid = good;
        crc_error = !good;
        tick();
        crc_valid = 1'b0;
        crc_error = 1'b0;
    endtask

    // Expected words: byte k of a word sits in lane DB-1-k, missing lanes zero, tlast on the end.
    task automatic model_push(input int len);
        int nw;
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        nw = (len + DB - 1) / DB;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < DB; j++) begin
                if (w * DB + j < len) begin
                    d[8*(DB-1-j) +: 8] = fr[w*DB + j];
                    k[DB-1-j]          = 1'b1;
                end
            end
            exp_q.push_back(64'({d, k, (w == nw - 1)}));
        end
    endtask

    task automatic fill_seq(input int len, input logic [7:0] first);
        for (int i = 0; i < len; i++) fr[i] = first + 8'(i);
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int t0;
        int len;
        int kind;

        repeat (3) tick();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_pulses", 64'({frame_ok, drop_crc, drop_ovf, drop_tmo}), 64'd0);
        aresetn = 1'b1;
        repeat (2) tick();

        // 8-byte frame 01..08, held with tready low.
        fill_seq(8, 8'h01);
        send_frame(8, 0);
        model_push(8);
        fcs(1'b1);
        exp_ok++;
        check("t1_frame_ok", 64'(frame_ok), 64'd1);
        check("t1_level", 64'(fifo_level), 64'd2);
        tick();
        check("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("t1_head", obs_word(), exp_q[0]);
        tick();
        check("t1_ok_pulse_end", 64'(frame_ok), 64'd0);
        check("t1_head_stall", obs_word(), exp_q[0]);
        rdy_mode = 1;
        wait_drain("t1_drain");
        check("t1_level_end", 64'(fifo_level), 64'd0);

        // 5-byte frame AA..EE, partial last word.
        fill_seq(5, 8'hAA);
        fr[1] = 8'hBB; fr[2] = 8'hCC; fr[3] = 8'hDD; fr[4] = 8'hEE;
        send_frame(5, 0);
        model_push(5);
        fcs(1'b1);
        exp_ok++;
        check("t2_frame_ok", 64'(frame_ok), 64'd1);
        wait_drain("t2_drain");

        // 12-byte frame with crc_error, then a good 4-byte frame.
        fill_rand(12);
        send_frame(12, 1);
        fcs(1'b0);
        exp_crc++;
        check("t3_drop_crc", 64'(drop_crc), 64'd1);
        check("t3_no_ok", 64'(frame_ok), 64'd0);
        repeat (3) tick();
        check("t3_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t3_level", 64'(fifo_level), 64'd0);
        fill_seq(4, 8'h11);
        send_frame(4, 0);
        model_push(4);
        fcs(1'b1);
        exp_ok++;
        check("t3_good_ok", 64'(frame_ok), 64'd1);
        wait_drain("t3_drain");

        // Overflow: two committed words, then a 40-byte frame that cannot fit.
        rdy_mode = 0;
        repeat (2) tick();
        fill_seq(8, 8'h40);
        send_frame(8, 0);
        model_push(8);
        fcs(1'b1);
        exp_ok++;
        fill_rand(40);
        send_frame(40, 0);
        fcs(1'b1);
        exp_ovf++;
        check("t4_drop_ovf", 64'(drop_ovf), 64'd1);
        check("t4_no_ok", 64'(frame_ok), 64'd0);
        check("t4_level", 64'(fifo_level), 64'd2);
        rdy_mode = 1;
        wait_drain("t4_drain");
        check("t4_level_end", 64'(fifo_level), 64'd0);

        // FCS timeout.
        fill_seq(4, 8'h21);
        send_frame(4, 0);
        n = 0;
        while (!drop_tmo && n < 40) begin
            tick();
            n++;
        end
        exp_tmo++;
        check("t5_tmo_cycle", 64'(n), 64'(TMO));
        check("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_level", 64'(fifo_level), 64'd0);

        // Preemption: a new frame arrives while the previous one awaits its FCS.
        fill_seq(4, 8'h31);
        send_frame(4, 0);
        repeat (3) tick();
        t0 = cnt_tmo;
        fill_seq(6, 8'h61);
        send_frame(6, 0);
        exp_tmo++;
        check("t6_preempt_drop", 64'(cnt_tmo - t0), 64'd1);
        model_push(6);
        fcs(1'b1);
        exp_ok++;
        check("t6_frame_ok", 64'(frame_ok), 64'd1);
        wait_drain("t6_drain");

        // Three back-to-back 6-byte frames with tready toggling.
        rdy_mode = 3;
        for (int f = 0; f < 3; f++) begin
            fill_seq(6, 8'(8'h80 + 8'(f * 16)));
            send_frame(6, 0);
            model_push(6);
            fcs(1'b1);
            exp_ok++;
            check("t7_frame_ok", 64'(frame_ok), 64'd1);
        end
        wait_drain("t7_drain");

        // Randomized frames, outcomes and backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 16);
            n = 0;
            while (exp_q.size() + (len + DB - 1) / DB > DEPTH - 1 && n < 300) begin
                tick();
                n++;
            end
            check("rnd_space_wait", 64'(n < 300), 64'd1);
            fill_rand(len);
            kind = $urandom_range(0, 9);
            send_frame(len, 2);
            repeat ($urandom_range(0, 4)) tick();
            if (kind < 7) begin
                model_push(len);
                fcs(1'b1);
                exp_ok++;
                check("rnd_frame_ok", 64'(frame_ok), 64'd1);
            end else if (kind == 7) begin
                fcs(1'b0);
                exp_crc++;
                check("rnd_drop_crc", 64'(drop_crc), 64'd1);
            end else begin
                exp_tmo++;
            end
        end
        repeat (TMO + 4) tick();
        rdy_mode = 1;
        wait_drain("rnd_drain");

        // Asynchronous reset mid-frame discards committed data and the open frame.
        rdy_mode = 0;
        repeat (2) tick();
        fill_seq(4, 8'h51);
        send_frame(4, 0);
        fcs(1'b1);
        exp_ok++;
        tick();
        for (int i = 0; i < 3; i++) begin
            data_in        = 8'hC0 + 8'(i);
            udp_data_valid = 1'b1;
            tick();
        end
        udp_data_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_mid_level", 64'(fifo_level), 64'd0);
        tick();
        aresetn = 1'b1;
        tick();
        rdy_mode = 1;
        fill_seq(4, 8'hD1);
        send_frame(4, 0);
        model_push(4);
        fcs(1'b1);
        exp_ok++;
        check("rst_after_ok", 64'(frame_ok), 64'd1);
        wait_drain("rst_after_drain");

        check("cnt_frame_ok", 64'(cnt_ok), 64'(exp_ok));
        check("cnt_drop_crc", 64'(cnt_crc), 64'(exp_crc));
        check("cnt_drop_ovf", 64'(cnt_ovf), 64'(exp_ovf));
        check("cnt_drop_tmo", 64'(cnt_tmo), 64'(exp_tmo));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
